// File: rtl/uart_tx_fifo.sv
// UART transmitter with an integrated transmit FIFO and a valid/ready push port.
// Frame format (5..DBIT_MAX data bits, parity, 1 or 2 stop bits) is captured from
// the config inputs when a frame leaves IDLE and then held in a frame shadow.
// Optional line-break generation is enabled by defining UART_TX_BREAK_EN, which
// adds the break_req input and a BREAK state.
module uart_tx_fifo #(
    parameter int DBIT_MAX   = 8,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          s_tick,
    input  logic [DBIT_MAX-1:0]           din,
    input  logic                          din_valid,
    output logic                          din_ready,
    input  logic [3:0]                    data_bits,
    input  logic [1:0]                    parity_mode,
    input  logic                          stop_bits,
`ifdef UART_TX_BREAK_EN
    input  logic                          break_req,
`endif
    output logic                          tx,
    output logic                          tx_done_tick,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(2 * OVERSAMPLE);
    localparam int NW = $clog2(DBIT_MAX);

    localparam logic [AW:0]   DEPTH_C  = (AW + 1)'(FIFO_DEPTH);
    localparam logic [TW-1:0] OS_LAST  = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] OS2_LAST = TW'(2 * OVERSAMPLE - 1);

`ifdef UART_TX_BREAK_EN
    localparam int BW = $clog2((DBIT_MAX + 2) * OVERSAMPLE + 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;
`endif

    // Transmit FIFO storage and bookkeeping
    logic [DBIT_MAX-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]       r_wptr;
    logic [AW-1:0]       r_rptr;
    logic [AW:0]         r_count;
    logic                w_push;
    logic                w_pop;
    logic [DBIT_MAX-1:0] w_head;

    // Frame shadow and FSM state
    state_t              r_state;
    logic [DBIT_MAX-1:0] r_shift;
    logic [NW-1:0]       r_lastBit;
    logic [NW-1:0]       r_bitIdx;
    logic [TW-1:0]       r_tick;
    logic                r_parEn;
    logic                r_parBit;
    logic                r_stop2;
    logic                r_tx;
    logic                r_doneTick;

    // Frame parameters derived from the FIFO head and the live config inputs
    logic [NW-1:0]       w_lastBit;
    logic [DBIT_MAX-1:0] w_frameData;
    logic                w_parEn;
    logic                w_parBit;
    logic [TW-1:0]       w_stopLast;

`ifdef UART_TX_BREAK_EN
    logic [BW-1:0]       r_brkCnt;
    logic [BW-1:0]       r_brkLimit;
    logic                r_fromBreak;
    logic [BW-1:0]       w_brkLimit;
`endif

    assign w_push = din_valid && din_ready;
`ifdef UART_TX_BREAK_EN
    assign w_pop  = (r_state == ST_IDLE) && (r_count != '0) && !break_req;
`else
    assign w_pop  = (r_state == ST_IDLE) && (r_count != '0);
`endif
    assign w_head     = r_mem[r_rptr];
    assign w_stopLast = r_stop2 ? OS2_LAST : OS_LAST;

    // Clamp the bit count to 5..DBIT_MAX, mask unused din bits and precompute parity
    always_comb begin
        w_lastBit = NW'(DBIT_MAX - 1);
        if (data_bits < 4'd5) begin
            w_lastBit = NW'(4);
        end else if (32'(data_bits) < 32'(DBIT_MAX)) begin
            w_lastBit = NW'(data_bits - 4'd1);
        end
        w_frameData = '0;
        for (int i = 0; i < DBIT_MAX; i++) begin
            if (NW'(i) <= w_lastBit) begin
                w_frameData[i] = w_head[i];
            end
        end
        w_parEn  = (parity_mode == 2'b01) || (parity_mode == 2'b10);
        w_parBit = (^w_frameData) ^ (parity_mode == 2'b10);
    end

`ifdef UART_TX_BREAK_EN
    assign w_brkLimit = BW'((int'(w_lastBit) + 3) * OVERSAMPLE);
`endif

    // FIFO storage write; contents need no reset because the pointers are cleared
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= din;
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leaves the count unchanged
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Frame FSM: tx and the done pulse are registered alongside the state
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_shift    <= '0;
            r_lastBit  <= '0;
            r_bitIdx   <= '0;
            r_tick     <= '0;
            r_parEn    <= 1'b0;
            r_parBit   <= 1'b0;
            r_stop2    <= 1'b0;
            r_tx       <= 1'b1;
            r_doneTick <= 1'b0;
`ifdef UART_TX_BREAK_EN
            r_brkCnt    <= '0;
            r_brkLimit  <= '0;
            r_fromBreak <= 1'b0;
`endif
        end else begin
            r_doneTick <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_tx <= 1'b1;
`ifdef UART_TX_BREAK_EN
                    if (break_req) begin
                        r_state    <= ST_BREAK;
                        r_tx       <= 1'b0;
                        r_brkCnt   <= '0;
                        r_brkLimit <= w_brkLimit;
                    end else
`endif
                    if (w_pop) begin
                        r_shift   <= w_frameData;
                        r_lastBit <= w_lastBit;
                        r_parEn   <= w_parEn;
                        r_parBit  <= w_parBit;
                        r_stop2   <= stop_bits;
                        r_tick    <= '0;
                        r_tx      <= 1'b0;
                        r_state   <= ST_START;
`ifdef UART_TX_BREAK_EN
                        r_fromBreak <= 1'b0;
`endif
                    end
                end
                ST_START: begin
                    if (s_tick) begin
                        if (r_tick == OS_LAST) begin
                            r_tick   <= '0;
                            r_bitIdx <= '0;
                            r_tx     <= r_shift[0];
                            r_state  <= ST_DATA;
                        end else begin
                            r_tick <= r_tick + 1'b1;
                        end
                    end
                end
                ST_DATA: begin
                    if (s_tick) begin
                        if (r_tick == OS_LAST) begin
                            r_tick <= '0;
                            if (r_bitIdx == r_lastBit) begin
                                if (r_parEn) begin
                                    r_tx    <= r_parBit;
                                    r_state <= ST_PARITY;
                                end else begin
                                    r_tx    <= 1'b1;
                                    r_state <= ST_STOP;
                                end
                            end else begin
                                r_shift  <= r_shift >> 1;
                                r_bitIdx <= r_bitIdx + 1'b1;
                                r_tx     <= r_shift[1];
                            end
                        end else begin
                            r_tick <= r_tick + 1'b1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (s_tick) begin
                        if (r_tick == OS_LAST) begin
                            r_tick  <= '0;
                            r_tx    <= 1'b1;
                            r_state <= ST_STOP;
                        end else begin
                            r_tick <= r_tick + 1'b1;
                        end
                    end
                end
                ST_STOP: begin
                    r_tx <= 1'b1;
                    if (s_tick) begin
                        if (r_tick == w_stopLast) begin
                            r_tick  <= '0;
                            r_state <= ST_IDLE;
`ifdef UART_TX_BREAK_EN
                            r_doneTick <= !r_fromBreak;
`else
                            r_doneTick <= 1'b1;
`endif
                        end else begin
                            r_tick <= r_tick + 1'b1;
                        end
                    end
                end
`ifdef UART_TX_BREAK_EN
                ST_BREAK: begin
                    r_tx <= 1'b0;
                    if (s_tick && (r_brkCnt != r_brkLimit)) begin
                        r_brkCnt <= r_brkCnt + 1'b1;
                    end
                    if (!break_req && (r_brkCnt == r_brkLimit)) begin
                        r_tx        <= 1'b1;
                        r_tick      <= '0;
                        r_stop2     <= 1'b0;
                        r_fromBreak <= 1'b1;
                        r_state     <= ST_STOP;
                    end
                end
`endif
                default: begin
                    r_tx    <= 1'b1;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign tx           = r_tx;
    assign tx_done_tick = r_doneTick;
    assign busy         = (r_state != ST_IDLE);
    assign fifo_count   = r_count;
    assign din_ready    = (r_count != DEPTH_C);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: a serial-line monitor decodes every frame
// on tx and compares it with frames queued when pushes were accepted.
// Break generation is exercised when UART_TX_BREAK_EN is defined.
module tb_uart_tx_fifo;

    localparam int OS = 16;

    typedef struct {
        logic [7:0] data;
        int         nb;
        logic       parEn;
        logic       parBit;
        logic       stop2;
    } frame_t;

    typedef struct {
        logic [7:0] din;
        logic [3:0] dbits;
        logic [1:0] pmode;
        logic       stop;
        int         expNb;
        logic       expParEn;
        logic       expParBit;
    } vec_t;

    logic       clk;
    logic       reset_n;
    logic       s_tick;
    logic [7:0] din;
    logic       din_valid;
    logic       din_ready;
    logic [3:0] data_bits;
    logic [1:0] parity_mode;
    logic       stop_bits;
    logic       tx;
    logic       tx_done_tick;
    logic       busy;
    logic [3:0] fifo_count;
`ifdef UART_TX_BREAK_EN
    logic       break_req;
`endif

    int     testsRun = 0;
    int     failCount = 0;
    frame_t sbQueue[$];
    logic   tickEn = 1'b0;
    logic   monEnable = 1'b1;
    logic   checkGap = 1'b0;
    int     extraDone = 0;
    int     unexpectedFrames = 0;
    int     monState = 0;

    uart_tx_fifo #(
        .DBIT_MAX  (8),
        .OVERSAMPLE(OS),
        .FIFO_DEPTH(8)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .s_tick      (s_tick),
        .din         (din),
        .din_valid   (din_valid),
        .din_ready   (din_ready),
        .data_bits   (data_bits),
        .parity_mode (parity_mode),
        .stop_bits   (stop_bits),
`ifdef UART_TX_BREAK_EN
        .break_req   (break_req),
`endif
        .tx          (tx),
        .tx_done_tick(tx_done_tick),
        .busy        (busy),
        .fifo_count  (fifo_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One-clock s_tick every third cycle while enabled
    initial begin
        int ph;
        ph = 0;
        s_tick = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            ph = (ph == 2) ? 0 : ph + 1;
            s_tick = tickEn && (ph == 0);
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic frame_t mkFrame(input logic [7:0] d, input int nb, input logic pe,
                                       input logic pb, input logic s2);
        frame_t f;
        f.data = d; f.nb = nb; f.parEn = pe; f.parBit = pb; f.stop2 = s2;
        return f;
    endfunction

    task automatic applyStimulus(input logic [7:0] d, input logic expAccept, input frame_t exp);
        @(negedge clk);
        din = d;
        din_valid = 1'b1;
        checkOutput("dinReady", {31'd0, din_ready}, {31'd0, expAccept});
        @(posedge clk);
        if (expAccept) sbQueue.push_back(exp);
        #1 din_valid = 1'b0;
    endtask

    task automatic waitIdle(input int maxCycles, input string name);
        int n;
        n = 0;
        while ((sbQueue.size() != 0 || monState != 0 || busy) && n < maxCycles) begin
            @(posedge clk);
            n++;
        end
        if (n >= maxCycles) begin
            testsRun++;
            failCount++;
            $display("[TB] FAIL %s: timeout after %0d cycles, queue=%0d", name, n, sbQueue.size());
        end
    endtask

    // Serial-line monitor: decodes each frame tick by tick and checks it against the scoreboard
    frame_t      cur;
    int          tickIdx;
    int          frameLen;
    int          idleCycles = 0;
    logic [15:0] expPat;
    logic [15:0] obsPat;
    logic        unstable;
    logic        earlyDone;
    always @(negedge clk) begin
        if (!reset_n || !monEnable) begin
            monState = 0;
            idleCycles = 0;
        end else if (monState == 2) begin
            checkOutput("frameBits", {16'd0, obsPat}, {16'd0, expPat});
            checkOutput("frameStable", {30'd0, unstable, earlyDone}, 32'd0);
            checkOutput("doneTick", {31'd0, tx_done_tick}, 32'd1);
            idleCycles = 0;
            monState = 0;
        end else begin
            if (monState == 0) begin
                idleCycles++;
                if (tx_done_tick) extraDone++;
                if (tx === 1'b0) begin
                    if (sbQueue.size() == 0) begin
                        unexpectedFrames++;
                        cur = mkFrame(8'h00, 8, 1'b0, 1'b0, 1'b0);
                    end else begin
                        cur = sbQueue.pop_front();
                    end
                    if (checkGap) checkOutput("b2bGap", idleCycles, 1);
                    expPat = '1;
                    expPat[0] = 1'b0;
                    for (int i = 0; i < cur.nb; i++) expPat[1 + i] = cur.data[i];
                    if (cur.parEn) expPat[1 + cur.nb] = cur.parBit;
                    frameLen = 1 + cur.nb + (cur.parEn ? 1 : 0) + (cur.stop2 ? 2 : 1);
                    obsPat = '1;
                    tickIdx = 0;
                    unstable = 1'b0;
                    earlyDone = 1'b0;
                    monState = 1;
                end
            end
            if (monState == 1) begin
                if (tx_done_tick) earlyDone = 1'b1;
                if (s_tick) begin
                    if ((tickIdx % OS) == 0) obsPat[tickIdx / OS] = tx;
                    else if (tx !== obsPat[tickIdx / OS]) unstable = 1'b1;
                    tickIdx++;
                    if (tickIdx == frameLen * OS) monState = 2;
                end
            end
        end
    end

    initial begin
        vec_t vecs[8];
        int   n;
        logic bad;

        vecs[0] = '{8'hA5, 4'd8,  2'b00, 1'b0, 8, 1'b0, 1'b0};
        vecs[1] = '{8'h03, 4'd7,  2'b01, 1'b1, 7, 1'b1, 1'b0};
        vecs[2] = '{8'h03, 4'd7,  2'b10, 1'b1, 7, 1'b1, 1'b1};
        vecs[3] = '{8'h5A, 4'd8,  2'b10, 1'b0, 8, 1'b1, 1'b1};
        vecs[4] = '{8'hFF, 4'd3,  2'b01, 1'b0, 5, 1'b1, 1'b1};
        vecs[5] = '{8'h81, 4'd15, 2'b01, 1'b0, 8, 1'b1, 1'b0};
        vecs[6] = '{8'h3C, 4'd6,  2'b11, 1'b0, 6, 1'b0, 1'b0};
        vecs[7] = '{8'hE7, 4'd5,  2'b10, 1'b1, 5, 1'b1, 1'b0};

        reset_n = 1'b0;
        din = 8'h00;
        din_valid = 1'b0;
        data_bits = 4'd8;
        parity_mode = 2'b00;
        stop_bits = 1'b0;
`ifdef UART_TX_BREAK_EN
        break_req = 1'b0;
`endif

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rstTx", {31'd0, tx}, 32'd1);
        checkOutput("rstDone", {31'd0, tx_done_tick}, 32'd0);
        checkOutput("rstBusy", {31'd0, busy}, 32'd0);
        checkOutput("rstCount", {28'd0, fifo_count}, 32'd0);
        checkOutput("rstReady", {31'd0, din_ready}, 32'd1);
        @(negedge clk);
        reset_n = 1'b1;

        // First-frame latency: push at E0, start bit at E1
        applyStimulus(8'hA5, 1'b1, mkFrame(8'hA5, 8, 1'b0, 1'b0, 1'b0));
        checkOutput("txAfterE0", {31'd0, tx}, 32'd1);
        checkOutput("countAfterE0", {28'd0, fifo_count}, 32'd1);
        @(posedge clk);
        #1;
        checkOutput("txAtE1", {31'd0, tx}, 32'd0);
        checkOutput("busyAtE1", {31'd0, busy}, 32'd1);
        checkOutput("countAtE1", {28'd0, fifo_count}, 32'd0);
        tickEn = 1'b1;
        waitIdle(5000, "latencyFrame");
        checkOutput("busyFalls", {31'd0, busy}, 32'd0);

        // Table of frame formats
        for (int i = 0; i < 8; i++) begin
            data_bits = vecs[i].dbits;
            parity_mode = vecs[i].pmode;
            stop_bits = vecs[i].stop;
            applyStimulus(vecs[i].din, 1'b1,
                          mkFrame(vecs[i].din, vecs[i].expNb, vecs[i].expParEn,
                                  vecs[i].expParBit, vecs[i].stop));
            waitIdle(5000, "tableFrame");
        end

        // Config change mid-frame applies only to the next frame
        data_bits = 4'd8;
        parity_mode = 2'b00;
        stop_bits = 1'b0;
        applyStimulus(8'hC6, 1'b1, mkFrame(8'hC6, 8, 1'b0, 1'b0, 1'b0));
        applyStimulus(8'h15, 1'b1, mkFrame(8'h15, 5, 1'b0, 1'b0, 1'b0));
        repeat (20) @(posedge clk);
        data_bits = 4'd5;
        waitIdle(5000, "midCfg");
        data_bits = 4'd8;

        // Fill the FIFO while the FSM waits for ticks, then drain back-to-back
        tickEn = 1'b0;
        repeat (4) @(posedge clk);
        applyStimulus(8'h10, 1'b1, mkFrame(8'h10, 8, 1'b0, 1'b0, 1'b0));
        repeat (3) @(posedge clk);
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(8'h10 + 8'(i), 1'b1, mkFrame(8'h10 + 8'(i), 8, 1'b0, 1'b0, 1'b0));
        end
        checkOutput("fullCount", {28'd0, fifo_count}, 32'd8);
        checkOutput("fullReady", {31'd0, din_ready}, 32'd0);
        applyStimulus(8'h19, 1'b0, mkFrame(8'h19, 8, 1'b0, 1'b0, 1'b0));
        checkOutput("rejectCount", {28'd0, fifo_count}, 32'd8);
        checkGap = 1'b1;
        tickEn = 1'b1;
        waitIdle(12000, "burst");
        checkGap = 1'b0;

        // Reset during DATA aborts the frame and flushes the FIFO
        applyStimulus(8'hF0, 1'b1, mkFrame(8'hF0, 8, 1'b0, 1'b0, 1'b0));
        applyStimulus(8'h0F, 1'b1, mkFrame(8'h0F, 8, 1'b0, 1'b0, 1'b0));
        repeat (120) @(posedge clk);
        @(negedge clk);
        checkOutput("txBeforeReset", {31'd0, tx}, 32'd0);
        reset_n = 1'b0;
        sbQueue.delete();
        @(posedge clk);
        #1;
        checkOutput("midRstTx", {31'd0, tx}, 32'd1);
        checkOutput("midRstCount", {28'd0, fifo_count}, 32'd0);
        checkOutput("midRstDone", {31'd0, tx_done_tick}, 32'd0);
        checkOutput("midRstBusy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || tx_done_tick !== 1'b0) bad = 1'b1;
        end
        checkOutput("postRstIdle", {31'd0, bad}, 32'd0);

`ifdef UART_TX_BREAK_EN
        // Break: line held low while requested, then one stop bit of mark, no done pulse
        monEnable = 1'b0;
        @(negedge clk);
        break_req = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("breakTx", {31'd0, tx}, 32'd0);
        checkOutput("breakBusy", {31'd0, busy}, 32'd1);
        applyStimulus(8'h55, 1'b1, mkFrame(8'h55, 8, 1'b0, 1'b0, 1'b0));
        bad = 1'b0;
        n = 0;
        while (n < 300) begin
            @(negedge clk);
            if (s_tick) begin
                n++;
                if (tx !== 1'b0) bad = 1'b1;
            end
        end
        checkOutput("breakLow", {31'd0, bad}, 32'd0);
        checkOutput("breakNoPop", {28'd0, fifo_count}, 32'd1);
        break_req = 1'b0;
        bad = 1'b0;
        n = 0;
        while (n < 16) begin
            @(negedge clk);
            if (tx_done_tick) bad = 1'b1;
            if (s_tick) begin
                n++;
                if (tx !== 1'b1) bad = 1'b1;
            end
        end
        checkOutput("breakMark", {31'd0, bad}, 32'd0);
        monEnable = 1'b1;
        waitIdle(5000, "afterBreak");
`endif

        checkOutput("extraDone", extraDone, 32'd0);
        checkOutput("unexpectedFrames", unexpectedFrames, 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
